// File: rtl/cpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_if
// Bundles the decoder qualifiers (inputs to the sequencer) and the phase
// strobes / status (outputs of the sequencer) of the EE1 instruction-cycle
// sequencer. The master modport is the sequencer side. The slave modport is
// the decoder/datapath side.
// -----------------------------------------------------------------------------
interface cpu_sequencer_if #(
    parameter int NPHASE = 3,
    parameter int CNT_W  = 16
);
    // decoder -> sequencer
    logic              STALL;
    logic [NPHASE-2:0] EXTRA;
    logic              RET;
    logic              HALT_REQ;
    logic              RESUME;
    // sequencer -> datapath
    logic              FETCH;
    logic [NPHASE-1:0] EXEC;
    logic [2:0]        PHASE;
    logic              HALTED;
    logic              RETIRE;
    logic [CNT_W-1:0]  ICOUNT;

    modport master (
        input  STALL, EXTRA, RET, HALT_REQ, RESUME,
        output FETCH, EXEC, PHASE, HALTED, RETIRE, ICOUNT
    );

    modport slave (
        output STALL, EXTRA, RET, HALT_REQ, RESUME,
        input  FETCH, EXEC, PHASE, HALTED, RETIRE, ICOUNT
    );
endinterface

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Registered FETCH / EXEC1..EXECn / HALT sequencer for the EE1 CPU. It has a
// memory stall, halt/resume and a retired-instruction counter.
// Optional feature macro: SEQ_OVERLAP_EN. When this macro is defined, the
// final exec cycle of a non-redirecting instruction also fetches, and the
// next state is EXEC1 directly.
// State encoding matches PHASE: 0 = FETCH, k = EXECk, 7 = HALT. The unused
// encodings above NPHASE recover to FETCH.
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int NPHASE = 3,   // legal range 2..6
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRESET,
    cpu_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC1 = 3'd1,
        ST_EXEC2 = 3'd2,
        ST_EXEC3 = 3'd3,
        ST_EXEC4 = 3'd4,
        ST_EXEC5 = 3'd5,
        ST_EXEC6 = 3'd6,
        ST_HALT  = 3'd7
    } state_e;

    state_e            state_r;
    state_e            next_state_s;
    logic [CNT_W-1:0]  icount_r;

    logic              in_exec_s;
    logic              final_s;
    logic              retire_s;
    logic              overlap_s;
    logic [7:0]        extra_pad_s;
    logic [2:0]        extra_idx_s;
    logic [NPHASE-1:0] exec_s;

    // EXTRA is zero-extended to 8 bits. This lets the phase index select
    // EXTRA[k-1] without going out of range. The bit for the last phase
    // is never consulted, because that phase is always final.
    assign extra_pad_s = {{(9-NPHASE){1'b0}}, bus.EXTRA};
    assign extra_idx_s = state_r - 3'd1;

    assign in_exec_s = (state_r != ST_FETCH) && (state_r <= 3'(NPHASE));
    assign final_s   = in_exec_s &&
                       ((state_r == 3'(NPHASE)) || !extra_pad_s[extra_idx_s]);
    assign retire_s  = final_s && !bus.STALL;

`ifdef SEQ_OVERLAP_EN
    // Fetch the next instruction alongside the final exec phase, unless the
    // instruction redirects the PC or halts.
    assign overlap_s = retire_s && !bus.RET && !bus.HALT_REQ;
`else
    logic unused_ret_s;
    assign overlap_s    = 1'b0;
    assign unused_ret_s = bus.RET;
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: a single combinational level from state and inputs.
    always_comb begin
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH: begin
                if (bus.STALL) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_EXEC1;
                end
            end
            ST_HALT: begin
                if (bus.RESUME) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            default: begin
                if (!in_exec_s) begin
                    next_state_s = ST_FETCH;          // illegal encoding
                end else if (bus.STALL) begin
                    next_state_s = state_r;
                end else if (!final_s) begin
                    next_state_s = state_e'(state_r + 3'd1);
                end else if (bus.HALT_REQ) begin
                    next_state_s = ST_HALT;
                end else if (overlap_s) begin
                    next_state_s = ST_EXEC1;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
        endcase
    end

    // One-hot exec strobe decoded from the registered state.
    always_comb begin
        exec_s = {NPHASE{1'b0}};
        for (int k = 0; k < NPHASE; k++) begin
            exec_s[k] = (state_r == state_e'(3'(k + 1)));
        end
    end

    // Retired-instruction counter. It wraps naturally at all-ones.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            icount_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            icount_r <= icount_r + CNT_W'(1);
        end else begin
            icount_r <= icount_r;
        end
    end

    assign bus.FETCH  = (state_r == ST_FETCH) || overlap_s;
    assign bus.EXEC   = exec_s;
    assign bus.PHASE  = state_r;
    assign bus.HALTED = (state_r == ST_HALT);
    assign bus.RETIRE = retire_s;
    assign bus.ICOUNT = icount_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed checks of cpu_sequencer with NPHASE = 3. A second instance with a
// 4-bit counter shares the same stimulus. It is used to reach the counter
// wrap in a few cycles.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic CLK = 1'b0;
    logic nRESET;
    int   tests_run    = 0;
    int   tests_failed = 0;

    cpu_sequencer_if #(.NPHASE(3), .CNT_W(16)) bus ();
    cpu_sequencer_if #(.NPHASE(3), .CNT_W(4))  bus2 ();

    cpu_sequencer #(.NPHASE(3), .CNT_W(16)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    cpu_sequencer #(.NPHASE(3), .CNT_W(4)) dut2 (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus2)
    );

    assign bus2.STALL    = bus.STALL;
    assign bus2.EXTRA    = bus.EXTRA;
    assign bus2.RET      = bus.RET;
    assign bus2.HALT_REQ = bus.HALT_REQ;
    assign bus2.RESUME   = bus.RESUME;

    always #5 CLK = ~CLK;

    // Reset is asserted for one edge. The task returns just after a negedge,
    // with the state at FETCH.
    task automatic apply_reset();
        @(negedge CLK);
        nRESET       = 1'b0;
        bus.STALL    = 1'b0;
        bus.EXTRA    = 2'b00;
        bus.RET      = 1'b1;
        bus.HALT_REQ = 1'b0;
        bus.RESUME   = 1'b0;
        @(negedge CLK);
        nRESET = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nRESET       = 1'b0;
        bus.STALL    = 1'b1;
        bus.EXTRA    = 2'b11;
        bus.RET      = 1'b1;
        bus.HALT_REQ = 1'b1;
        bus.RESUME   = 1'b1;
        @(negedge CLK);
        #1;
        tests_run++;
        if ({bus.FETCH, bus.EXEC, bus.PHASE, bus.HALTED, bus.RETIRE} !== {1'b1, 3'b000, 3'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: FETCH=%b EXEC=%b PHASE=%0d HALTED=%b RETIRE=%b, expected 1 000 0 0 0",
                     bus.FETCH, bus.EXEC, bus.PHASE, bus.HALTED, bus.RETIRE);
        end
        tests_run++;
        if (bus.ICOUNT !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_icount: got %h expected 0000", bus.ICOUNT);
        end
    endtask

    task automatic test_short_instr();
        apply_reset();
        bus.EXTRA = 2'b00;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests_run++;
            if (bus.PHASE !== 3'(i % 2) || bus.RETIRE !== 1'(i % 2) || bus.ICOUNT !== 16'(i / 2)) begin
                tests_failed++;
                $display("FAIL short_instr cyc %0d: PHASE=%0d RETIRE=%b ICOUNT=%0d expected %0d %0d %0d",
                         i, bus.PHASE, bus.RETIRE, bus.ICOUNT, i % 2, i % 2, i / 2);
            end
            @(negedge CLK);
        end
        #1;
        tests_run++;
        if (bus.ICOUNT !== 16'd3) begin
            tests_failed++;
            $display("FAIL short_icount: got %0d expected 3", bus.ICOUNT);
        end
    endtask

    task automatic test_long_instr();
        int ph_e[5]   = '{0, 1, 2, 3, 0};
        int ex_e[5]   = '{0, 1, 2, 4, 0};
        int re_e[5]   = '{0, 0, 0, 1, 0};
        int fe_e[5]   = '{1, 0, 0, 0, 1};
        apply_reset();
        bus.EXTRA = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (bus.PHASE !== 3'(ph_e[i]) || bus.EXEC !== 3'(ex_e[i]) ||
                bus.RETIRE !== 1'(re_e[i]) || bus.FETCH !== 1'(fe_e[i])) begin
                tests_failed++;
                $display("FAIL long_instr cyc %0d: PHASE=%0d EXEC=%b RETIRE=%b FETCH=%b expected %0d %b %0d %0d",
                         i, bus.PHASE, bus.EXEC, bus.RETIRE, bus.FETCH, ph_e[i], 3'(ex_e[i]), re_e[i], fe_e[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_stall();
        int st_v[10] = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 0};
        int ex_v[10] = '{3, 3, 3, 3, 3, 3, 3, 0, 0, 0};
        int ph_e[10] = '{0, 1, 2, 2, 2, 3, 0, 1, 1, 0};
        int re_e[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        int ic_e[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            bus.STALL = 1'(st_v[i]);
            bus.EXTRA = 2'(ex_v[i]);
            #1;
            tests_run++;
            if (bus.PHASE !== 3'(ph_e[i]) || bus.RETIRE !== 1'(re_e[i]) || bus.ICOUNT !== 16'(ic_e[i])) begin
                tests_failed++;
                $display("FAIL stall cyc %0d: PHASE=%0d RETIRE=%b ICOUNT=%0d expected %0d %0d %0d",
                         i, bus.PHASE, bus.RETIRE, bus.ICOUNT, ph_e[i], re_e[i], ic_e[i]);
            end
            @(negedge CLK);
        end
        bus.STALL = 1'b0;
    endtask

    task automatic test_halt();
        int hr_v[10] = '{1, 1, 0, 1, 0, 0, 0, 0, 1, 0};
        int st_v[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        int rs_v[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        int ph_e[10] = '{0, 1, 7, 7, 7, 7, 7, 7, 0, 1};
        int re_e[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        int fe_e[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int ic_e[10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        apply_reset();
        bus.EXTRA = 2'b00;
        for (int i = 0; i < 10; i++) begin
            bus.HALT_REQ = 1'(hr_v[i]);
            bus.STALL    = 1'(st_v[i]);
            bus.RESUME   = 1'(rs_v[i]);
            #1;
            tests_run++;
            if (bus.PHASE !== 3'(ph_e[i]) || bus.HALTED !== (ph_e[i] == 7) ||
                bus.RETIRE !== 1'(re_e[i]) || bus.FETCH !== 1'(fe_e[i]) || bus.ICOUNT !== 16'(ic_e[i])) begin
                tests_failed++;
                $display("FAIL halt cyc %0d: PHASE=%0d HALTED=%b RETIRE=%b FETCH=%b ICOUNT=%0d expected %0d %0d %0d %0d %0d",
                         i, bus.PHASE, bus.HALTED, bus.RETIRE, bus.FETCH, bus.ICOUNT,
                         ph_e[i], ph_e[i] == 7, re_e[i], fe_e[i], ic_e[i]);
            end
            @(negedge CLK);
        end
        bus.HALT_REQ = 1'b0;
        bus.STALL    = 1'b0;
        bus.RESUME   = 1'b0;
    endtask

    task automatic test_reset_mid_and_wrap();
        apply_reset();
        // one short instruction so the counter is non-zero
        bus.EXTRA = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        tests_run++;
        if (bus.ICOUNT !== 16'd1) begin
            tests_failed++;
            $display("FAIL mid_pre_icount: got %0d expected 1", bus.ICOUNT);
        end
        // reach EXEC2, then reset while stalled
        bus.EXTRA = 2'b11;
        @(negedge CLK);
        @(negedge CLK);
        bus.STALL = 1'b1;
        nRESET    = 1'b0;
        #1;
        tests_run++;
        if (bus.PHASE !== 3'd2) begin
            tests_failed++;
            $display("FAIL mid_in_exec2: PHASE=%0d expected 2", bus.PHASE);
        end
        @(negedge CLK);
        #1;
        tests_run++;
        if (bus.PHASE !== 3'd0 || bus.FETCH !== 1'b1 || bus.EXEC !== 3'b000 || bus.ICOUNT !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: PHASE=%0d FETCH=%b EXEC=%b ICOUNT=%0d expected 0 1 000 0",
                     bus.PHASE, bus.FETCH, bus.EXEC, bus.ICOUNT);
        end
        nRESET    = 1'b1;
        bus.STALL = 1'b0;
        // reset while halted
        bus.EXTRA    = 2'b00;
        bus.HALT_REQ = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        bus.HALT_REQ = 1'b0;
        nRESET       = 1'b0;
        #1;
        tests_run++;
        if (bus.HALTED !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_before_reset: HALTED=%b expected 1", bus.HALTED);
        end
        @(negedge CLK);
        nRESET = 1'b1;
        #1;
        tests_run++;
        if (bus.PHASE !== 3'd0 || bus.HALTED !== 1'b0 || bus.ICOUNT !== 16'd0) begin
            tests_failed++;
            $display("FAIL halt_reset: PHASE=%0d HALTED=%b ICOUNT=%0d expected 0 0 0",
                     bus.PHASE, bus.HALTED, bus.ICOUNT);
        end
        // 15 short instructions take the 4-bit counter to all-ones
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
        end
        #1;
        tests_run++;
        if (bus2.ICOUNT !== 4'hF || bus.ICOUNT !== 16'd15) begin
            tests_failed++;
            $display("FAIL wrap_pre: ICOUNT4=%h ICOUNT16=%0d expected f 15", bus2.ICOUNT, bus.ICOUNT);
        end
        @(negedge CLK);
        @(negedge CLK);
        #1;
        tests_run++;
        if (bus2.ICOUNT !== 4'h0 || bus.ICOUNT !== 16'd16) begin
            tests_failed++;
            $display("FAIL wrap: ICOUNT4=%h ICOUNT16=%0d expected 0 16", bus2.ICOUNT, bus.ICOUNT);
        end
    endtask

    task automatic test_overlap();
`ifdef SEQ_OVERLAP_EN
        int rt_v[7] = '{0, 0, 0, 0, 0, 1, 0};
        int ph_e[7] = '{0, 1, 1, 1, 1, 1, 0};
        int fe_e[7] = '{1, 1, 1, 1, 1, 0, 1};
        int re_e[7] = '{0, 1, 1, 1, 1, 1, 0};
`else
        int rt_v[7] = '{0, 0, 0, 0, 0, 1, 0};
        int ph_e[7] = '{0, 1, 0, 1, 0, 1, 0};
        int fe_e[7] = '{1, 0, 1, 0, 1, 0, 1};
        int re_e[7] = '{0, 1, 0, 1, 0, 1, 0};
`endif
        apply_reset();
        bus.EXTRA = 2'b00;
        for (int i = 0; i < 7; i++) begin
            bus.RET = 1'(rt_v[i]);
            #1;
            tests_run++;
            if (bus.PHASE !== 3'(ph_e[i]) || bus.FETCH !== 1'(fe_e[i]) || bus.RETIRE !== 1'(re_e[i])) begin
                tests_failed++;
                $display("FAIL overlap cyc %0d: PHASE=%0d FETCH=%b RETIRE=%b expected %0d %0d %0d",
                         i, bus.PHASE, bus.FETCH, bus.RETIRE, ph_e[i], fe_e[i], re_e[i]);
            end
            @(negedge CLK);
        end
        bus.RET = 1'b1;
    endtask

    initial begin
        nRESET       = 1'b0;
        bus.STALL    = 1'b0;
        bus.EXTRA    = 2'b00;
        bus.RET      = 1'b1;
        bus.HALT_REQ = 1'b0;
        bus.RESUME   = 1'b0;
        test_reset();
        test_short_instr();
        test_long_instr();
        test_stall();
        test_halt();
        test_reset_mid_and_wrap();
        test_overlap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
